direction_scoring_system3: RTL and testbench



---
 rtl/direction_scoring_system3.sv | 66 ++++++
 tb/tb_direction_scoring_system3.sv | 93 +++++++++
 2 files changed

// File: rtl/direction_scoring_system3.sv
// Travel-direction selector for two 6-floor cars: each car's registered direction
// follows the larger of its up/down request scores and holds its value on a tie.
module direction_scoring_system3 (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] FloorDestinations,
    input  logic [11:0] FloorsRequested,
    input  logic [7:0]  half_elevatorPositions,
    output logic [1:0]  directions
);

    localparam int unsigned NFLOORS = 6;
    localparam int unsigned NCARS   = 2;
    localparam int unsigned W_DEST  = 2;
    localparam int unsigned W_REQ   = 1;
    localparam int unsigned POS_W   = 4;
    localparam int unsigned SCORE_W = 5;
    localparam int unsigned TOP_POS = 2 * (NFLOORS - 1);

    logic [NFLOORS-1:0] dest       [NCARS];
    logic [NFLOORS-1:0] req        [NCARS];
    logic [POS_W-1:0]   pos        [NCARS];
    logic [SCORE_W-1:0] up_score   [NCARS];
    logic [SCORE_W-1:0] down_score [NCARS];
    logic [NCARS-1:0]   next_dir;

    function automatic logic [SCORE_W-1:0] floor_weight(input logic d, input logic r);
        floor_weight = (d ? SCORE_W'(W_DEST) : SCORE_W'(0)) + (r ? SCORE_W'(W_REQ) : SCORE_W'(0));
    endfunction

    // Per-car scoring; a floor level with the car contributes to neither score.
    always_comb begin
        next_dir = directions;
        for (int c = 0; c < NCARS; c++) begin
            dest[c]       = FloorDestinations[c*NFLOORS +: NFLOORS];
            req[c]        = FloorsRequested[c*NFLOORS +: NFLOORS];
            pos[c]        = half_elevatorPositions[c*POS_W +: POS_W];
            up_score[c]   = '0;
            down_score[c] = '0;
            if (pos[c] > POS_W'(TOP_POS)) begin
                pos[c] = POS_W'(TOP_POS);
            end
            for (int f = 0; f < NFLOORS; f++) begin
                if (POS_W'(2 * f) > pos[c]) begin
                    up_score[c] = up_score[c] + floor_weight(dest[c][f], req[c][f]);
                end else if (POS_W'(2 * f) < pos[c]) begin
                    down_score[c] = down_score[c] + floor_weight(dest[c][f], req[c][f]);
                end
            end
            if (up_score[c] > down_score[c]) begin
                next_dir[c] = 1'b1;
            end else if (down_score[c] > up_score[c]) begin
                next_dir[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            directions <= 2'b11;
        end else begin
            directions <= next_dir;
        end
    end

endmodule

// File: tb/tb_direction_scoring_system3.sv
// Scoreboard bench: the driver queues hand-computed expected directions per cycle,
// and a monitor pops and compares them just after each rising edge.
module tb_direction_scoring_system3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] FloorDestinations = '0;
    logic [11:0] FloorsRequested = '0;
    logic [7:0]  half_elevatorPositions = '0;
    logic [1:0]  directions;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q  [$];
    string      name_q [$];

    direction_scoring_system3 dut (
        .clk                    (clk),
        .rst                    (rst),
        .FloorDestinations      (FloorDestinations),
        .FloorsRequested        (FloorsRequested),
        .half_elevatorPositions (half_elevatorPositions),
        .directions             (directions)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] p, input logic [11:0] d,
                        input logic [11:0] q, input logic [1:0] exp, input string nm);
        @(negedge clk);
        rst                    = r;
        half_elevatorPositions = p;
        FloorDestinations      = d;
        FloorsRequested        = q;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: output is presented every cycle, compare whatever is queued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [1:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (directions !== e) begin
                    errors++;
                    $display("FAIL %s: directions=%b expected=%b", n, directions, e);
                end
            end
        end
    end

    initial begin
        step(1, 8'h00, 12'h000, 12'h000, 2'b11, "reset");
        step(0, 8'h00, 12'h000, 12'h000, 2'b11, "idle_hold1");
        step(0, 8'h00, 12'h000, 12'h000, 2'b11, "idle_hold2");
        step(0, 8'h08, 12'h001, 12'h000, 2'b10, "left_down");
        step(0, 8'h04, 12'h011, 12'h000, 2'b10, "tie_hold0");
        step(0, 8'h04, 12'h000, 12'h008, 2'b11, "left_up_req");
        step(0, 8'h04, 12'h011, 12'h000, 2'b11, "tie_hold1");
        step(0, 8'h04, 12'h001, 12'h000, 2'b10, "left_down2");
        step(0, 8'h04, 12'h001, 12'h038, 2'b11, "req_up3_vs_dest2");
        step(0, 8'h04, 12'h001, 12'h018, 2'b11, "mixed_tie_hold1");
        step(0, 8'h04, 12'h001, 12'h000, 2'b10, "left_down3");
        step(0, 8'h04, 12'h001, 12'h018, 2'b10, "mixed_tie_hold0");
        step(0, 8'h60, 12'h040, 12'h000, 2'b00, "right_down_only");
        step(0, 8'hF0, 12'h000, 12'h800, 2'b00, "right_clamp_hold0");
        step(1, 8'h60, 12'h040, 12'h000, 2'b11, "mid_reset");
        step(0, 8'hF0, 12'h000, 12'h800, 2'b11, "right_clamp_hold1");
        step(0, 8'hF0, 12'h400, 12'h000, 2'b01, "right_clamp_down");
        step(0, 8'h00, 12'h001, 12'h000, 2'b01, "left_at_floor0");
        step(0, 8'h0A, 12'h020, 12'h001, 2'b00, "left_top_down");
        step(0, 8'h03, 12'h004, 12'h002, 2'b01, "left_between_up");
        step(0, 8'h50, 12'h200, 12'h100, 2'b11, "right_between_up");
        step(0, 8'h28, 12'h801, 12'h000, 2'b10, "both_cars_opposite");
        step(0, 8'h00, 12'h000, 12'h000, 2'b10, "idle_after");
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
